// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start qualification,
// centre sampling of each data bit, stop-bit check with one-cycle strobes.
module uart_rx #(
    parameter real SYSCLOCK = 27.0,
    parameter real BAUDRATE = 1.0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_bsy
);

    localparam int CLKPERBIT = int'(SYSCLOCK / BAUDRATE);
    localparam int HALFBIT   = CLKPERBIT / 2;
    localparam int CW        = $clog2(CLKPERBIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALFBIT - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKPERBIT - 1);

    generate
        if (CLKPERBIT < 4) begin : g_bad_ratio
            $error("uart_rx: SYSCLOCK/BAUDRATE must give at least 4 clocks per bit");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic          s1_reg;
    logic          rx_s;
    logic [1:0]    fill_reg;
    logic          armed_reg;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    logic [7:0]    shift_reg;

    // armed only once the synchroniser carries real pin data and the line is
    // high, so a line that is low at reset release is not taken as a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= 1'b1;
            rx_s      <= 1'b1;
            fill_reg  <= 2'b00;
            armed_reg <= 1'b0;
        end else begin
            s1_reg   <= rx;
            rx_s     <= s1_reg;
            fill_reg <= {fill_reg[0], 1'b1};
            if (fill_reg[1] && rx_s) begin
                armed_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_bsy    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (armed_reg && !rx_s) begin
                        state_reg <= START;
                        rx_bsy    <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_reg == CNT_HALF) begin
                        cnt_reg <= '0;
                        idx_reg <= 3'd0;
                        if (rx_s) begin
                            state_reg <= IDLE;
                            rx_bsy    <= 1'b0;
                        end else begin
                            state_reg <= DATA;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == CNT_BIT) begin
                        cnt_reg            <= '0;
                        shift_reg[idx_reg] <= rx_s;
                        idx_reg            <= idx_reg + 3'd1;
                        if (idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    // Checked mid stop bit, leaving half a bit to catch the next start edge.
                    if (cnt_reg == CNT_BIT) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            rx_data   <= shift_reg;
                            rx_valid  <= 1'b1;
                            state_reg <= IDLE;
                            rx_bsy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_reg <= IDLE;
                        rx_bsy    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rx_bsy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
